// File: rtl/student_iis_sample_fifo_if.sv
// Bundles the IIS receive push side and the FIR consume side of the stereo sample FIFO.
// The FIFO takes the slave modport; the producer/consumer (or bench) takes the master modport.
interface student_iis_sample_fifo_if #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 8
);
  logic [DATA_SIZE-1:0]       Data_I_L;
  logic [DATA_SIZE-1:0]       Data_I_R;
  logic                       valid_strobe_I;
  logic                       clear_i;
  logic [DATA_SIZE-1:0]       Data_O_L;
  logic [DATA_SIZE-1:0]       Data_O_R;
  logic                       valid_o;
  logic                       ready_i;
  logic [$clog2(DEPTH):0]     level_o;
  logic                       overflow_o;
  logic [CNT_W-1:0]           drop_cnt_o;

  modport slave (
    input  Data_I_L, Data_I_R, valid_strobe_I, clear_i, ready_i,
    output Data_O_L, Data_O_R, valid_o, level_o, overflow_o, drop_cnt_o
  );

  modport master (
    output Data_I_L, Data_I_R, valid_strobe_I, clear_i, ready_i,
    input  Data_O_L, Data_O_R, valid_o, level_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/student_iis_sample_fifo.sv
// Stereo {L,R} sample FIFO with a registered first-word-fall-through head, sticky overflow
// and a saturating drop counter. Handshake: head is consumed when valid_o && ready_i.
module student_iis_sample_fifo #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  student_iis_sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2 * DATA_SIZE;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    head_q, head_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic          full, pop, push, drop;
  logic [EW-1:0] in_word;

  assign in_word = {bus.Data_I_L, bus.Data_I_R};
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // valid_q mirrors non-empty, so pop never underflows.
  assign pop     = valid_q && bus.ready_i;
  assign push    = bus.valid_strobe_I && !bus.clear_i && (!full || pop);
  assign drop    = bus.valid_strobe_I && !bus.clear_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (bus.clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + 1'b1;
      end
      valid_d = (wr_ptr_d != rd_ptr_d);
      // The next head is the sample being written this cycle when the read pointer lands on
      // the old write slot; otherwise it is already in storage.
      if (valid_d) begin
        if (rd_ptr_d == wr_ptr_q) head_d = in_word;
        else                      head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_word;
  end

  assign bus.Data_O_L   = head_q[EW-1:DATA_SIZE];
  assign bus.Data_O_R   = head_q[DATA_SIZE-1:0];
  assign bus.valid_o    = valid_q;
  assign bus.level_o    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow_o = ovf_q;
  assign bus.drop_cnt_o = drop_q;
endmodule

// File: tb/tb_student_iis_sample_fifo.sv
// Directed bench for the stereo sample FIFO at DEPTH=4: vector table for steady-state traffic,
// hand sequences for saturation, clear and asynchronous reset.
module tb_student_iis_sample_fifo;
  localparam int DS = 16;
  localparam int DP = 4;
  localparam int CW = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  student_iis_sample_fifo_if #(.DATA_SIZE(DS), .DEPTH(DP), .CNT_W(CW)) bus ();

  student_iis_sample_fifo #(.DATA_SIZE(DS), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          strobe;
    logic [15:0]   l;
    logic [15:0]   r;
    logic          ready;
    logic          exp_valid;
    logic [15:0]   exp_l;
    logic [15:0]   exp_r;
    logic [2:0]    exp_level;
    logic          exp_ovf;
    logic [7:0]    exp_drop;
  } vec_t;

  vec_t vq[$];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic strobe, input logic [15:0] l, input logic [15:0] r,
                       input logic ready, input logic clear);
    bus.valid_strobe_I = strobe;
    bus.Data_I_L       = l;
    bus.Data_I_R       = r;
    bus.ready_i        = ready;
    bus.clear_i        = clear;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [15:0] l,
                           input logic [15:0] r, input logic [2:0] lvl,
                           input logic ovf, input logic [7:0] drp);
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
    if (v) begin
      chk({tag, ".L"}, 32'(bus.Data_O_L), 32'(l));
      chk({tag, ".R"}, 32'(bus.Data_O_R), 32'(r));
    end
    chk({tag, ".level"}, 32'(bus.level_o), 32'(lvl));
    chk({tag, ".ovf"}, 32'(bus.overflow_o), 32'(ovf));
    chk({tag, ".drop"}, 32'(bus.drop_cnt_o), 32'(drp));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // strobe, L, R, ready | valid, headL, headR, level, ovf, drop (state after the edge)
    // single sample passes straight through
    vq.push_back(vec_t'{1, 16'h1234, 16'hABCD, 1, 1, 16'h1234, 16'hABCD, 1, 0, 0});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0});
    // fill to 4 with ready low
    vq.push_back(vec_t'{1, 16'h0001, 16'hFFFE, 0, 1, 16'h0001, 16'hFFFE, 1, 0, 0});
    vq.push_back(vec_t'{1, 16'h0002, 16'hFFFD, 0, 1, 16'h0001, 16'hFFFE, 2, 0, 0});
    vq.push_back(vec_t'{1, 16'h0003, 16'hFFFC, 0, 1, 16'h0001, 16'hFFFE, 3, 0, 0});
    vq.push_back(vec_t'{1, 16'h0004, 16'hFFFB, 0, 1, 16'h0001, 16'hFFFE, 4, 0, 0});
    // two drops while full
    vq.push_back(vec_t'{1, 16'h0005, 16'hFFFA, 0, 1, 16'h0001, 16'hFFFE, 4, 1, 1});
    vq.push_back(vec_t'{1, 16'h0005, 16'hFFFA, 0, 1, 16'h0001, 16'hFFFE, 4, 1, 2});
    // drain 1..4, sample 5 absent
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 1, 16'h0002, 16'hFFFD, 3, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 1, 16'h0003, 16'hFFFC, 2, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 1, 16'h0004, 16'hFFFB, 1, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 2});
    // refill, then push+pop while full
    vq.push_back(vec_t'{1, 16'h0011, 16'hFFEE, 0, 1, 16'h0011, 16'hFFEE, 1, 1, 2});
    vq.push_back(vec_t'{1, 16'h0012, 16'hFFED, 0, 1, 16'h0011, 16'hFFEE, 2, 1, 2});
    vq.push_back(vec_t'{1, 16'h0013, 16'hFFEC, 0, 1, 16'h0011, 16'hFFEE, 3, 1, 2});
    vq.push_back(vec_t'{1, 16'h0014, 16'hFFEB, 0, 1, 16'h0011, 16'hFFEE, 4, 1, 2});
    vq.push_back(vec_t'{1, 16'h0015, 16'hFFEA, 1, 1, 16'h0012, 16'hFFED, 4, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 1, 16'h0013, 16'hFFEC, 3, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 1, 16'h0014, 16'hFFEB, 2, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 1, 16'h0015, 16'hFFEA, 1, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 2});
    // push into empty with ready high, then push+pop at level 1 (no bubble)
    vq.push_back(vec_t'{1, 16'h0021, 16'h5521, 1, 1, 16'h0021, 16'h5521, 1, 1, 2});
    vq.push_back(vec_t'{1, 16'h0022, 16'h5522, 1, 1, 16'h0022, 16'h5522, 1, 1, 2});
    vq.push_back(vec_t'{0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 2});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_state("reset", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 8'h00);
    chk("reset.dataL", 32'(bus.Data_O_L), 32'h0);
    chk("reset.dataR", 32'(bus.Data_O_R), 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].strobe, vq[i].l, vq[i].r, vq[i].ready, 1'b0);
      tick();
      chk_state($sformatf("vec%0d", i), vq[i].exp_valid, vq[i].exp_l, vq[i].exp_r,
                vq[i].exp_level, vq[i].exp_ovf, vq[i].exp_drop);
    end

    // drop counter saturation: fill, 252 drops -> FE, 48 more -> FF
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'(16'h0040 + k), 16'(16'hC040 + k), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 252; k++) begin
      drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
      tick();
    end
    chk_state("sat_fe", 1'b1, 16'h0040, 16'hC040, 3'd4, 1'b1, 8'hFE);
    for (int k = 0; k < 48; k++) begin
      drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
      tick();
    end
    chk_state("sat_ff", 1'b1, 16'h0040, 16'hC040, 3'd4, 1'b1, 8'hFF);

    // clear with a coincident strobe: strobe discarded
    drive(1'b1, 16'h9999, 16'h6666, 1'b0, 1'b1);
    tick();
    chk_state("clear", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 8'h00);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_state("clear_idle", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 8'h00);
    drive(1'b1, 16'h5A5A, 16'hA5A5, 1'b0, 1'b0);
    tick();
    chk_state("post_clear", 1'b1, 16'h5A5A, 16'hA5A5, 3'd1, 1'b0, 8'h00);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();

    // async reset mid-drain at level 3
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'(16'h0031 + k), 16'(16'hB031 + k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    chk_state("pre_rst", 1'b1, 16'h0032, 16'hB032, 3'd3, 1'b0, 8'h00);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 8'h00);
    chk("async_rst.dataL", 32'(bus.Data_O_L), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0077, 16'h0088, 1'b0, 1'b0);
    tick();
    chk_state("post_rst", 1'b1, 16'h0077, 16'h0088, 3'd1, 1'b0, 8'h00);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_state("post_rst_hold", 1'b1, 16'h0077, 16'h0088, 3'd1, 1'b0, 8'h00);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
